// File: rtl/chan_if.sv
// chan_if: request/response bus between the CPU channel controller and the channel dispatcher.
`ifndef CPU_MSG_SIZE0
`define CPU_MSG_SIZE0 3
`define ADDR_SIZE0 15
`define DATA_SIZE0 31
`define CPU_R_CHAN_CRT 4'h8
`define CPU_R_CHAN_SET 4'h9
`define CPU_R_CHAN_GET 4'hA
`define CPU_R_CHAN_TST 4'hB
`define CPU_R_CHAN_DEL 4'hC
`define CPU_R_CHAN_DONE 4'hD
`endif

interface chan_if;
    logic [`CPU_MSG_SIZE0:0] cpu_msg_in;
    logic                    cpu_msg_pulse;
    logic [`ADDR_SIZE0:0]    addr_in;
    logic [`DATA_SIZE0:0]    data_in;
    logic [`CPU_MSG_SIZE0:0] cpu_msg_out;
    logic [`DATA_SIZE0:0]    data_out;
    logic                    busy;
    modport master (output cpu_msg_in, cpu_msg_pulse, addr_in, data_in,
                    input  cpu_msg_out, data_out, busy);
    modport slave  (input  cpu_msg_in, cpu_msg_pulse, addr_in, data_in,
                    output cpu_msg_out, data_out, busy);
endinterface

// File: rtl/chan_dispatcher.sv
// chan_dispatcher: services channel create/set/get/test/delete requests over a table of FIFOs,
// answering each accepted request with a held DONE response.
`ifndef CPU_MSG_SIZE0
`define CPU_MSG_SIZE0 3
`define ADDR_SIZE0 15
`define DATA_SIZE0 31
`define CPU_R_CHAN_CRT 4'h8
`define CPU_R_CHAN_SET 4'h9
`define CPU_R_CHAN_GET 4'hA
`define CPU_R_CHAN_TST 4'hB
`define CPU_R_CHAN_DEL 4'hC
`define CPU_R_CHAN_DONE 4'hD
`endif

module chan_dispatcher #(
    parameter int NCHAN     = 8,
    parameter int DEPTH     = 4,
    parameter int RESP_HOLD = 2
) (
    input logic   clk,
    input logic   rst,
    chan_if.slave bus
);
    localparam int IW = NCHAN > 1 ? $clog2(NCHAN) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int HW = RESP_HOLD > 1 ? $clog2(RESP_HOLD) : 1;
    localparam int AW = `ADDR_SIZE0 + 1;
    localparam int DW = `DATA_SIZE0 + 1;
    localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;

    logic [1:0]              state;
    logic [HW-1:0]           hold;
    logic [`CPU_MSG_SIZE0:0] code, msg_q;
    logic [AW-1:0]           addr;
    logic [DW-1:0]           data, dout_q, result;
    logic [NCHAN-1:0]        alloc;
    logic [PW-1:0]           rd_ptr [NCHAN];
    logic [PW-1:0]           wr_ptr [NCHAN];
    logic [PW:0]             cnt    [NCHAN];
    logic [DW-1:0]           mem    [NCHAN][DEPTH];
    logic [IW-1:0]           idx, free_idx;
    logic                    free_found, valid, full, empty, accept, do_set, do_get;

    assign accept = state == IDLE && bus.cpu_msg_pulse &&
                    bus.cpu_msg_in inside {`CPU_R_CHAN_CRT, `CPU_R_CHAN_SET, `CPU_R_CHAN_GET,
                                           `CPU_R_CHAN_TST, `CPU_R_CHAN_DEL};
    assign idx    = IW'(addr - AW'(1));
    assign valid  = addr != '0 && addr <= AW'(NCHAN) && alloc[idx];
    assign full   = cnt[idx] == (PW+1)'(DEPTH);
    assign empty  = cnt[idx] == '0;
    assign do_set = state == EXEC && code == `CPU_R_CHAN_SET && valid && !full;
    assign do_get = state == EXEC && code == `CPU_R_CHAN_GET && valid && !empty;

    // Descending scan so the lowest free slot wins.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NCHAN - 1; i >= 0; i--)
            if (!alloc[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
    end

    always_comb
        result = code == `CPU_R_CHAN_CRT ? (free_found ? DW'(free_idx) + DW'(1) : '0) :
                 code == `CPU_R_CHAN_SET ? DW'(valid && !full) :
                 code == `CPU_R_CHAN_GET ? (valid && !empty ? mem[idx][rd_ptr[idx]] : '0) :
                 code == `CPU_R_CHAN_TST ? (valid ? DW'(cnt[idx]) : '0) :
                 DW'(valid);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state  <= IDLE;
            hold   <= '0;
            code   <= '0;
            addr   <= '0;
            data   <= '0;
            msg_q  <= '0;
            dout_q <= '0;
            alloc  <= '0;
            for (int i = 0; i < NCHAN; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            if (accept) begin
                state <= EXEC;
                code  <= bus.cpu_msg_in;
                addr  <= bus.addr_in;
                data  <= bus.data_in;
            end
            if (state == EXEC) begin
                state  <= RESP;
                hold   <= '0;
                msg_q  <= `CPU_R_CHAN_DONE;
                dout_q <= result;
                if (code == `CPU_R_CHAN_CRT && free_found) begin
                    alloc[free_idx]  <= 1'b1;
                    rd_ptr[free_idx] <= '0;
                    wr_ptr[free_idx] <= '0;
                    cnt[free_idx]    <= '0;
                end
                if (do_set) begin
                    wr_ptr[idx] <= wr_ptr[idx] + PW'(1);
                    cnt[idx]    <= cnt[idx] + (PW+1)'(1);
                end
                if (do_get) begin
                    rd_ptr[idx] <= rd_ptr[idx] + PW'(1);
                    cnt[idx]    <= cnt[idx] - (PW+1)'(1);
                end
                if (code == `CPU_R_CHAN_DEL && valid) begin
                    alloc[idx]  <= 1'b0;
                    rd_ptr[idx] <= '0;
                    wr_ptr[idx] <= '0;
                    cnt[idx]    <= '0;
                end
            end
            if (state == RESP) begin
                if (hold == HW'(RESP_HOLD - 1)) begin
                    state  <= IDLE;
                    msg_q  <= '0;
                    dout_q <= '0;
                end else
                    hold <= hold + HW'(1);
            end
        end

    // FIFO payload survives DEL/CRT; only pointers and counts are cleared.
    always_ff @(posedge clk)
        if (do_set) mem[idx][wr_ptr[idx]] <= data;

    assign bus.cpu_msg_out = msg_q;
    assign bus.data_out    = dout_q;
    assign bus.busy        = state != IDLE;
endmodule

// File: tb/tb_chan_dispatcher.sv
// tb_chan_dispatcher: directed plus randomized requests checked against a queue-based channel model.
`ifndef CPU_MSG_SIZE0
`define CPU_MSG_SIZE0 3
`define ADDR_SIZE0 15
`define DATA_SIZE0 31
`define CPU_R_CHAN_CRT 4'h8
`define CPU_R_CHAN_SET 4'h9
`define CPU_R_CHAN_GET 4'hA
`define CPU_R_CHAN_TST 4'hB
`define CPU_R_CHAN_DEL 4'hC
`define CPU_R_CHAN_DONE 4'hD
`endif

module tb_chan_dispatcher;
    localparam int NCH = 2;
    localparam int DEP = 2;
    localparam logic [3:0] CRT = `CPU_R_CHAN_CRT, SET = `CPU_R_CHAN_SET, GET = `CPU_R_CHAN_GET,
                           TST = `CPU_R_CHAN_TST, DEL = `CPU_R_CHAN_DEL, DONE = `CPU_R_CHAN_DONE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared = 0;
    int   mismatched = 0;
    bit          m_alloc [NCH];
    logic [31:0] m_q     [NCH][$];

    chan_if bus ();
    chan_dispatcher #(.NCHAN(NCH), .DEPTH(DEP), .RESP_HOLD(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_alloc[i] = 1'b0;
            m_q[i].delete();
        end
    endtask

    task automatic model(input logic [3:0] c, input logic [15:0] a, input logic [31:0] d,
                         output logic [31:0] e);
        int h;
        bit v;
        h = int'(a) - 1;
        v = (h >= 0 && h < NCH) ? m_alloc[h] : 1'b0;
        e = 0;
        case (c)
            CRT: for (int i = 0; i < NCH; i++)
                     if (!m_alloc[i]) begin
                         m_alloc[i] = 1'b1;
                         m_q[i].delete();
                         e = i + 1;
                         break;
                     end
            SET: if (v && m_q[h].size() < DEP) begin
                     m_q[h].push_back(d);
                     e = 1;
                 end
            GET: if (v && m_q[h].size() > 0) e = m_q[h].pop_front();
            TST: if (v) e = m_q[h].size();
            DEL: if (v) begin
                     m_alloc[h] = 1'b0;
                     m_q[h].delete();
                     e = 1;
                 end
            default: e = 0;
        endcase
    endtask

    // One full transaction; dup keeps the strobe high with a SET during the busy window.
    task automatic req(input logic [3:0] c, input logic [15:0] a, input logic [31:0] d,
                       input bit dup, input string tag);
        logic [31:0] e;
        model(c, a, d, e);
        @(negedge clk);
        bus.cpu_msg_in = c;
        bus.addr_in = a;
        bus.data_in = d;
        bus.cpu_msg_pulse = 1'b1;
        @(posedge clk); #1;
        if (dup) begin
            bus.cpu_msg_in = SET;
            bus.data_in = 32'hEE;
        end else bus.cpu_msg_pulse = 1'b0;
        check({tag, ".busy_rise"}, 32'(bus.busy), 1);
        check({tag, ".no_early"}, 32'(bus.cpu_msg_out), 0);
        @(posedge clk); #1;
        bus.cpu_msg_pulse = 1'b0;
        check({tag, ".done"}, 32'(bus.cpu_msg_out), 32'(DONE));
        check({tag, ".data"}, bus.data_out, e);
        @(posedge clk); #1;
        check({tag, ".done_hold"}, 32'(bus.cpu_msg_out), 32'(DONE));
        check({tag, ".data_hold"}, bus.data_out, e);
        check({tag, ".busy_hold"}, 32'(bus.busy), 1);
        @(posedge clk); #1;
        check({tag, ".done_fall"}, 32'(bus.cpu_msg_out), 0);
        check({tag, ".data_fall"}, bus.data_out, 0);
        check({tag, ".busy_fall"}, 32'(bus.busy), 0);
    endtask

    task automatic quiet(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check({tag, ".busy"}, 32'(bus.busy), 0);
            check({tag, ".msg"}, 32'(bus.cpu_msg_out), 0);
        end
    endtask

    initial begin
        logic [3:0] codes [5];
        codes = '{CRT, SET, GET, TST, DEL};
        bus.cpu_msg_in = '0;
        bus.addr_in = '0;
        bus.data_in = '0;
        bus.cpu_msg_pulse = 1'b0;
        model_reset();
        #1;
        check("rst.msg", 32'(bus.cpu_msg_out), 0);
        check("rst.data", bus.data_out, 0);
        check("rst.busy", 32'(bus.busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        req(CRT, 0, 0, 0, "crt1");
        req(CRT, 0, 0, 0, "crt2");
        req(CRT, 0, 0, 0, "crt_full");
        req(SET, 1, 32'hA5, 0, "set_a5");
        req(SET, 1, 32'h5A, 0, "set_5a");
        req(SET, 1, 32'h11, 0, "set_full");
        req(TST, 1, 0, 0, "tst_2");
        req(GET, 1, 0, 0, "get_a5");
        req(GET, 1, 0, 0, "get_5a");
        req(GET, 1, 0, 0, "get_empty");
        req(TST, 1, 0, 0, "tst_0");
        req(SET, 1, 32'h01, 0, "wset1");
        req(GET, 1, 0, 0, "wget1");
        req(SET, 1, 32'h02, 0, "wset2");
        req(SET, 1, 32'h03, 0, "wset3");
        req(GET, 1, 0, 0, "wget2");
        req(GET, 1, 0, 0, "wget3");
        req(DEL, 1, 0, 0, "del1");
        req(SET, 1, 32'h44, 0, "set_freed");
        req(DEL, 1, 0, 0, "del_again");
        req(CRT, 0, 0, 0, "crt_reuse");
        req(TST, 1, 0, 0, "tst_reused");
        req(SET, 0, 32'h9, 0, "set_h0");
        req(GET, 0, 0, 0, "get_h0");
        req(TST, 0, 0, 0, "tst_h0");
        req(SET, 3, 32'h9, 0, "set_h3");
        req(GET, 3, 0, 0, "get_h3");
        req(TST, 3, 0, 0, "tst_h3");
        req(SET, 16'h8001, 32'h9, 0, "set_hi_bits");

        @(negedge clk);
        bus.cpu_msg_in = 4'h1;
        bus.cpu_msg_pulse = 1'b1;
        @(negedge clk);
        bus.cpu_msg_pulse = 1'b0;
        quiet(3, "unknown");

        req(TST, 2, 0, 1, "dup_tst");
        quiet(3, "dup_after");
        req(TST, 2, 0, 0, "dup_noeffect");

        // Reset landing in the response window of a SET.
        @(negedge clk);
        bus.cpu_msg_in = SET;
        bus.addr_in = 1;
        bus.data_in = 32'h77;
        bus.cpu_msg_pulse = 1'b1;
        @(posedge clk); #1;
        bus.cpu_msg_pulse = 1'b0;
        @(posedge clk); #1;
        check("pre_rst.done", 32'(bus.cpu_msg_out), 32'(DONE));
        rst = 1'b1;
        #1;
        check("rst_mid.msg", 32'(bus.cpu_msg_out), 0);
        check("rst_mid.data", bus.data_out, 0);
        check("rst_mid.busy", 32'(bus.busy), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        quiet(3, "post_rst");
        req(TST, 1, 0, 0, "post_rst_tst");
        req(CRT, 0, 0, 0, "post_rst_crt");

        for (int n = 0; n < 200; n++)
            req(codes[$urandom_range(0, 4)], 16'($urandom_range(0, 3)), $urandom, 0, "rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
